scalar_alu_arbiter: RTL and testbench
=====================================

// Module: scalar_alu_arbiter
// PURPOSE
//  Shares the single 36-bit scalar ALU between two requesters: port 0 = scalar
//  pipeline issue, port 1 = address-generation / auxiliary unit. Each port has
//  a valid/ready request interface. The arbiter picks one grant per cycle and
//  drives the ALU operands, sign-extending a 25-bit immediate when the request
//  selects it. It tracks ALU_LAT cycles of in-flight ownership and returns the
//  result and flags (zero/sign/overflow) to the owning port.
// PARAMETERS
//  DATA_W       36  operand/result width
//  IMM_W        25  immediate width; sign-extended to DATA_W
//  OP_W          4  ALU opcode width
//  ALU_LAT       1  ALU cycles from operand drive to alu_out valid (>=1)
//  STARVE_LIMIT  8  consecutive lost cycles before port 1 forces priority
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  reqN_valid     in   1        port N (N=0,1) request valid
//  reqN_ready     out  1        port N request accepted this cycle
//  reqN_a         in   DATA_W   operand A
//  reqN_b         in   DATA_W   operand B (register source)
//  reqN_imm       in   IMM_W    immediate
//  reqN_use_imm   in   1        1: B = sext(imm); 0: B = reqN_b
//  reqN_op        in   OP_W     ALU opcode
//  flush0         in   1        kill all in-flight port-0 ops (branch redirect)
//  alu_a, alu_b   out  DATA_W   operands to the shared ALU
//  alu_op         out  OP_W     opcode to the ALU
//  alu_out        in   DATA_W   ALU result, ALU_LAT cycles after issue
//  alu_zero/sign/overflow in 1  ALU flags, aligned with alu_out
//  rspN_valid     out  1        one-cycle result pulse to port N (no backpressure)
//  rspN_data      out  DATA_W   result
//  rspN_zero/sign/overflow out 1  flags
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, ownership pipe cleared, starve cnt 0.
//    Ops in flight at reset are dropped; no rsp pulse after reset release.
//  - Arbitration, one grant per cycle, combinational on valids:
//    port 0 wins if valid, unless starve_cnt == STARVE_LIMIT and req1_valid;
//    then port 1 wins. Only valid requesters are granted.
//  - reqN_ready = grant to N; transfer = valid & ready. ready never asserts
//    without valid. Ports have no stall path; the ALU accepts every cycle.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) when req1_valid & !grant1;
//    cleared to 0 on grant1 or when req1_valid=0.
//  - alu_a/b/op are driven combinationally from the granted port; zeros if idle.
//    alu_b = use_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : b.
//  - Ownership pipe: ALU_LAT-deep shift of {valid, owner}; entry shifted in at
//    grant. At the pipe tail, rsp<owner>_valid pulses for exactly one cycle,
//    with data/flags registered from alu_out/flags. Latency issue->rsp = ALU_LAT+1.
//  - flush0: in the same cycle, clears valid on every pipe entry with owner 0 and
//    suppresses a port-0 grant that cycle. Port-1 entries are unaffected.
//    A port-0 rsp registered in the flush cycle still pulses.
//  - Back-to-back grants every cycle give full throughput. Results return in
//    issue order. At most one rsp pulse per cycle overall.
//  - rsp data/flags hold their last value while rsp valid is low.
// STRUCTURE
//  - scalar_pkg: DATA_W, IMM_W, OP_W localparams; alu_op_t enum; sext_imm()
//    function; owner_t (PORT_PIPE=0, PORT_AUX=1).
//  - One sub-module: alu_owner_pipe (ALU_LAT-deep {valid,owner} shifter with
//    selective owner-0 kill). The arbiter and rsp registers live in the top module.
//  - The ALU is instantiated by the parent, not inside this block.
// TESTING (bench models ALU_LAT-cycle ALU; default params)
//  1. req0 only, a=5, imm=-3 (0x1FFFFFD), use_imm, op=ADD -> alu_b=0xFFFFFFFFD;
//     rsp0_valid 2 cycles later, data=2; rsp1 never pulses.
//  2. Both valid every cycle for 20 cycles -> port 0 granted 8 cycles, port 1
//     granted cycle 9, pattern repeats; no grant while a port is invalid.
//  3. Alternating grants 0,1,0,1 -> rsp0/rsp1 pulses in the same order, each with
//     the correct data; one pulse per cycle.
//  4. Grant port 0 at cycle t, flush0 at t+1 (ALU_LAT=2 build) -> no rsp0 for that
//     op; a port-1 op issued at t+1 still returns.
//  5. rst_n low while 1 op is in flight -> all outputs 0 immediately; no stray rsp
//     after release; starve_cnt restarts from 0.
//  6. imm=0x0FFFFFF (positive max), use_imm, op=ADD, a=0x7FFFFFFFF -> overflow=1
//     reported on rsp0 with the correct wrapped sum.

Source files
------------

// File: rtl/scalar_alu_arbiter_pkg.sv
// scalar_pkg: shared widths, ALU opcode and owner encodings, immediate sign-extension.
package scalar_pkg;
   localparam int DATA_W = 36;
   localparam int IMM_W  = 25;
   localparam int OP_W   = 4;
   typedef enum logic [OP_W-1:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA
   } alu_op_t;
   typedef enum logic {PORT_PIPE = 1'b0, PORT_AUX = 1'b1} owner_t;
   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction
endpackage

// File: rtl/scalar_alu_arbiter_if.sv
// scalar_alu_arbiter_if: one requester's valid/ready issue channel plus its result return.
interface scalar_alu_arbiter_if;
   import scalar_pkg::*;
   logic              valid, ready, use_imm;
   logic [DATA_W-1:0] a, b;
   logic [IMM_W-1:0]  imm;
   logic [OP_W-1:0]   op;
   logic              rsp_valid, rsp_zero, rsp_sign, rsp_overflow;
   logic [DATA_W-1:0] rsp_data;
   modport master (output valid, a, b, imm, use_imm, op,
                   input  ready, rsp_valid, rsp_data, rsp_zero, rsp_sign, rsp_overflow);
   modport slave  (input  valid, a, b, imm, use_imm, op,
                   output ready, rsp_valid, rsp_data, rsp_zero, rsp_sign, rsp_overflow);
endinterface

// File: rtl/scalar_alu_arbiter_owner_pipe.sv
// alu_owner_pipe: tracks which port owns each ALU stage; flush0 kills port-0 entries as they advance.
module alu_owner_pipe
   import scalar_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   in_valid,
   input  owner_t in_owner,
   input  logic   flush0,
   output logic   tail_valid,
   output owner_t tail_owner
);
   logic [LAT-1:0] v, o;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v <= '0;
         o <= '0;
      end else begin
         v[0] <= in_valid;
         o[0] <= in_owner;
         for (int i = 1; i < LAT; i++) begin
            v[i] <= v[i-1] & ~(flush0 & (o[i-1] == PORT_PIPE));
            o[i] <= o[i-1];
         end
      end
   assign tail_valid = v[LAT-1];
   assign tail_owner = owner_t'(o[LAT-1]);
endmodule

// File: rtl/scalar_alu_arbiter.sv
// scalar_alu_arbiter: shares one scalar ALU between the issue pipe (port 0) and the aux unit (port 1),
// with starvation relief for port 1 and per-port result return.
module scalar_alu_arbiter
   import scalar_pkg::*;
#(
   parameter int ALU_LAT      = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   scalar_alu_arbiter_if.slave req0,
   scalar_alu_arbiter_if.slave req1,
   input  logic                flush0,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [OP_W-1:0]     alu_op,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic                alu_zero,
   input  logic                alu_sign,
   input  logic                alu_overflow
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;
   logic          starve, grant0, grant1, tail_valid, hit0, hit1;
   owner_t        tail_owner;
   // Grants are gated by rst_n so every output reads zero while reset is held.
   always_comb begin
      starve     = starve_cnt == SW'(STARVE_LIMIT);
      grant0     = rst_n & req0.valid & ~flush0 & ~(starve & req1.valid);
      grant1     = rst_n & req1.valid & ~grant0;
      req0.ready = grant0;
      req1.ready = grant1;
      alu_a      = grant0 ? req0.a : grant1 ? req1.a : '0;
      alu_b      = grant0 ? (req0.use_imm ? sext_imm(req0.imm) : req0.b)
                 : grant1 ? (req1.use_imm ? sext_imm(req1.imm) : req1.b) : '0;
      alu_op     = grant0 ? req0.op : grant1 ? req1.op : '0;
      hit0       = tail_valid & (tail_owner == PORT_PIPE);
      hit1       = tail_valid & (tail_owner == PORT_AUX);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         starve_cnt <= '0;
      else if (!req1.valid || grant1)
         starve_cnt <= '0;
      else if (!starve)
         starve_cnt <= starve_cnt + SW'(1);
   alu_owner_pipe #(.LAT(ALU_LAT)) u_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (grant0 | grant1),
      .in_owner   (grant1 ? PORT_AUX : PORT_PIPE),
      .flush0     (flush0),
      .tail_valid (tail_valid),
      .tail_owner (tail_owner)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         req0.rsp_valid    <= 1'b0;
         req0.rsp_data     <= '0;
         req0.rsp_zero     <= 1'b0;
         req0.rsp_sign     <= 1'b0;
         req0.rsp_overflow <= 1'b0;
         req1.rsp_valid    <= 1'b0;
         req1.rsp_data     <= '0;
         req1.rsp_zero     <= 1'b0;
         req1.rsp_sign     <= 1'b0;
         req1.rsp_overflow <= 1'b0;
      end else begin
         req0.rsp_valid <= hit0;
         req1.rsp_valid <= hit1;
         if (hit0) begin
            req0.rsp_data     <= alu_out;
            req0.rsp_zero     <= alu_zero;
            req0.rsp_sign     <= alu_sign;
            req0.rsp_overflow <= alu_overflow;
         end
         if (hit1) begin
            req1.rsp_data     <= alu_out;
            req1.rsp_zero     <= alu_zero;
            req1.rsp_sign     <= alu_sign;
            req1.rsp_overflow <= alu_overflow;
         end
      end
endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// tb_scalar_alu_arbiter: directed checks of arbitration, immediate extension, result return,
// flush and reset, against ALU_LAT=1 and ALU_LAT=2 builds with a behavioural ALU each.
module tb_scalar_alu_arbiter;
   import scalar_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, f1 = 1'b0, f2 = 1'b0;
   int   errors = 0, checks = 0;
   always #5 clk = ~clk;
   scalar_alu_arbiter_if p0 (), p1 (), q0 (), q1 ();
   logic [DATA_W-1:0] alu_a1, alu_b1, alu_out1, alu_a2, alu_b2, alu_out2;
   logic [OP_W-1:0]   alu_op1, alu_op2;
   logic [38:0]       m1, m2a, m2b;
   function automatic logic [38:0] alu_f(input logic [35:0] a, input logic [35:0] b, input logic [3:0] op);
      logic [35:0] r;
      logic        ov;
      r  = a;
      ov = 1'b0;
      case (op)
         4'(OP_ADD): begin r = a + b; ov = (a[35] == b[35]) && (r[35] != a[35]); end
         4'(OP_SUB): begin r = a - b; ov = (a[35] != b[35]) && (r[35] != a[35]); end
         4'(OP_AND): r = a & b;
         4'(OP_OR):  r = a | b;
         4'(OP_XOR): r = a ^ b;
         default:    r = a;
      endcase
      return {ov, r[35], r == 36'd0, r};
   endfunction
   always @(posedge clk) begin
      m1  <= alu_f(alu_a1, alu_b1, alu_op1);
      m2a <= alu_f(alu_a2, alu_b2, alu_op2);
      m2b <= m2a;
   end
   assign alu_out1 = m1[35:0];
   assign alu_out2 = m2b[35:0];
   scalar_alu_arbiter #(.ALU_LAT(1), .STARVE_LIMIT(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req0(p0), .req1(p1), .flush0(f1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_out(alu_out1),
      .alu_zero(m1[36]), .alu_sign(m1[37]), .alu_overflow(m1[38]));
   scalar_alu_arbiter #(.ALU_LAT(2), .STARVE_LIMIT(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req0(q0), .req1(q1), .flush0(f2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_out(alu_out2),
      .alu_zero(m2b[36]), .alu_sign(m2b[37]), .alu_overflow(m2b[38]));
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle;
      p0.valid = 0; p0.a = '0; p0.b = '0; p0.imm = '0; p0.use_imm = 0; p0.op = '0;
      p1.valid = 0; p1.a = '0; p1.b = '0; p1.imm = '0; p1.use_imm = 0; p1.op = '0;
      q0.valid = 0; q0.a = '0; q0.b = '0; q0.imm = '0; q0.use_imm = 0; q0.op = '0;
      q1.valid = 0; q1.a = '0; q1.b = '0; q1.imm = '0; q1.use_imm = 0; q1.op = '0;
   endtask
   logic [35:0] t3a [4] = '{36'd10, 36'd20, 36'hF0, 36'h800000000};
   logic [35:0] t3b [4] = '{36'd1, 36'd3, 36'h0F, 36'd0};
   logic [3:0]  t3o [4] = '{4'(OP_ADD), 4'(OP_SUB), 4'(OP_AND), 4'(OP_XOR)};
   logic [35:0] t3e [4] = '{36'd11, 36'd17, 36'd0, 36'h800000000};
   logic        t3w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic        t3z [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic        t3s [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   initial begin
      idle();
      p0.valid = 1; p0.a = 36'd5;
      tick();
      @(negedge clk);
      check("rst_rdy0", p0.ready, 0);
      check("rst_alu_a", alu_a1, 0);
      check("rst_rsp0", p0.rsp_valid, 0);
      check("rst_rdata0", p0.rsp_data, 0);
      tick();
      idle();
      rst_n = 1;
      // 1: immediate sign extension and two-cycle return
      p0.valid = 1; p0.a = 36'd5; p0.b = 36'd123; p0.imm = 25'h1FFFFFD; p0.use_imm = 1; p0.op = OP_ADD;
      @(negedge clk);
      check("t1_rdy0", p0.ready, 1);
      check("t1_rdy1", p1.ready, 0);
      check("t1_alu_a", alu_a1, 36'd5);
      check("t1_alu_b", alu_b1, 36'hFFFFFFFFD);
      tick();
      idle();
      @(negedge clk);
      check("t1_early", p0.rsp_valid, 0);
      tick();
      @(negedge clk);
      check("t1_rsp0", p0.rsp_valid, 1);
      check("t1_data", p0.rsp_data, 36'd2);
      check("t1_flags", {p0.rsp_zero, p0.rsp_sign, p0.rsp_overflow}, 3'b000);
      check("t1_rsp1", p1.rsp_valid, 0);
      tick();
      @(negedge clk);
      check("t1_pulse", p0.rsp_valid, 0);
      check("t1_hold", p0.rsp_data, 36'd2);
      tick();
      // 2: starvation relief every ninth cycle
      for (int i = 0; i < 20; i++) begin
         p0.valid = 1; p0.a = 36'(i); p0.op = OP_ADD;
         p1.valid = 1; p1.a = 36'(100 + i); p1.op = OP_ADD;
         @(negedge clk);
         check("t2_g1", p1.ready, (i % 9) == 8);
         check("t2_g0", p0.ready, (i % 9) != 8);
         check("t2_alu_a", alu_a1, (i % 9) == 8 ? 36'(100 + i) : 36'(i));
         tick();
      end
      idle();
      @(negedge clk);
      check("t2_idle", {p0.ready, p1.ready}, 2'b00);
      tick();
      p1.valid = 1; p1.a = 36'd1;
      @(negedge clk);
      check("t2_only1", {p0.ready, p1.ready}, 2'b01);
      tick();
      idle();
      repeat (3) tick();
      // 3: alternating owners return in issue order
      for (int j = 0; j < 6; j++) begin
         idle();
         if (j < 4) begin
            if (t3w[j]) begin p1.valid = 1; p1.a = t3a[j]; p1.b = t3b[j]; p1.op = t3o[j]; end
            else        begin p0.valid = 1; p0.a = t3a[j]; p0.b = t3b[j]; p0.op = t3o[j]; end
         end
         @(negedge clk);
         if (j >= 2) begin
            check("t3_v0", p0.rsp_valid, !t3w[j-2]);
            check("t3_v1", p1.rsp_valid, t3w[j-2]);
            check("t3_data", t3w[j-2] ? p1.rsp_data : p0.rsp_data, t3e[j-2]);
            check("t3_zs", t3w[j-2] ? {p1.rsp_zero, p1.rsp_sign} : {p0.rsp_zero, p0.rsp_sign}, {t3z[j-2], t3s[j-2]});
         end
         tick();
      end
      idle();
      // 6: max positive immediate overflows
      p0.valid = 1; p0.a = 36'h7FFFFFFFF; p0.imm = 25'h0FFFFFF; p0.use_imm = 1; p0.op = OP_ADD;
      @(negedge clk);
      check("t6_alu_b", alu_b1, 36'h000FFFFFF);
      tick();
      idle();
      tick();
      @(negedge clk);
      check("t6_rsp0", p0.rsp_valid, 1);
      check("t6_data", p0.rsp_data, 36'h800FFFFFE);
      check("t6_flags", {p0.rsp_zero, p0.rsp_sign, p0.rsp_overflow}, 3'b011);
      tick();
      // 5: async reset with ops in flight and starve count part-way
      for (int i = 0; i < 4; i++) begin
         p0.valid = 1; p0.a = 36'(i + 1); p0.op = OP_ADD;
         p1.valid = 1; p1.a = 36'(50 + i); p1.op = OP_ADD;
         tick();
      end
      rst_n = 0;
      #1;
      check("t5_rsp0", p0.rsp_valid, 0);
      check("t5_rdata0", p0.rsp_data, 0);
      check("t5_rdy", {p0.ready, p1.ready}, 2'b00);
      check("t5_alu", {alu_a1, alu_b1}, 72'd0);
      tick();
      tick();
      rst_n = 1;
      idle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t5_stray", {p0.rsp_valid, p1.rsp_valid}, 2'b00);
         tick();
      end
      for (int i = 0; i < 9; i++) begin
         p0.valid = 1; p1.valid = 1;
         @(negedge clk);
         check("t5_starve", p1.ready, i == 8);
         tick();
      end
      idle();
      repeat (3) tick();
      // 4: ALU_LAT=2 build, unflushed return then flush kill
      q0.valid = 1; q0.a = 36'd2; q0.b = 36'd3; q0.op = OP_ADD;
      @(negedge clk);
      check("t4_rdy0", q0.ready, 1);
      tick();
      idle();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("t4_lat", q0.rsp_valid, k == 3);
         tick();
      end
      check("t4_data", q0.rsp_data, 36'd5);
      q0.valid = 1; q0.a = 36'd7; q0.b = 36'd1; q0.op = OP_ADD;
      @(negedge clk);
      check("t4_issue0", q0.ready, 1);
      tick();
      q0.valid = 1; q0.a = 36'd9; f2 = 1;
      q1.valid = 1; q1.a = 36'd100; q1.b = 36'd5; q1.op = OP_ADD;
      @(negedge clk);
      check("t4_flush_rdy", {q0.ready, q1.ready}, 2'b01);
      check("t4_flush_alu", alu_a2, 36'd100);
      tick();
      idle();
      f2 = 0;
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         check("t4_killed", q0.rsp_valid, 0);
         check("t4_aux", q1.rsp_valid, k == 4);
         tick();
      end
      check("t4_aux_data", q1.rsp_data, 36'd105);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
